inst_fetch_buffer: RTL and testbench

- Fetch-side stage directly upstream of decode.
- Generates sequential PCs, issues word reads to instruction memory, and queues returned instructions with their PCs.
- Presents instructions to decode through a valid/ready handshake; decode slices id_inst[31:7] into the immediate generator.
- Handles branch/jump redirect from EX by flushing the queue and discarding in-flight responses.

---
 rtl/inst_fetch_buffer_pkg.sv | 18 +
 rtl/inst_fetch_buffer_if.sv | 30 +++
 rtl/inst_fetch_buffer_fifo.sv | 67 ++++++
 rtl/inst_fetch_buffer.sv | 106 ++++++++++
 tb/tb_inst_fetch_buffer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_buffer_pkg.sv
// Shared constants and types for the instruction fetch buffer.
// Holds default depth/reset PC, the queued entry layout and a PC alignment helper.
package inst_fetch_buffer_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FETCH_DEPTH      = 4;
  localparam int          INST_WIDTH       = 32;

  typedef struct packed {
    logic [31:0]           pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// Bundles the instruction-memory, redirect and decode-side signals of the fetch buffer.
// master = fetch buffer side, slave = memory / EX / decode environment side.
interface inst_fetch_buffer_if;
  import inst_fetch_buffer_pkg::*;

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [31:0]           imem_req_addr;
  logic                  imem_rsp_valid;
  logic [INST_WIDTH-1:0] imem_rsp_data;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  id_valid;
  logic                  id_ready;
  logic [INST_WIDTH-1:0] id_inst;
  logic [31:0]           id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/inst_fetch_buffer_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count; head is visible combinationally.
// Reads as zero while empty so downstream sees a clean value after reset.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = (cnt_q == '0) ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && cnt_q == FULL_CNT));

endmodule

// File: rtl/inst_fetch_buffer.sv
// Fetch stage ahead of decode: credit-limited sequential fetch, in-order response queue, redirect flush.
// Define FETCH_BYPASS_EN to let a response reach decode in its arrival cycle when the queue is empty.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  inst_fetch_buffer_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  logic          run_q;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] q_count, pcq_count;
  fetch_entry_t  q_head, q_wdata;
  logic [31:0]   pcq_head;
  logic          q_empty, req_hs, credit_ok, push, pop, byp_take;

  assign q_empty   = (q_count == '0);
  assign credit_ok = ({1'b0, q_count} + {1'b0, out_q}) < CREDIT_MAX;

  assign bus.imem_req_valid = run_q && !bus.redirect_valid && credit_ok;
  assign bus.imem_req_addr  = pc_q;
  assign req_hs             = bus.imem_req_valid && bus.imem_req_ready;

`ifdef FETCH_BYPASS_EN
  logic byp_avail;
  assign byp_avail    = run_q && bus.imem_rsp_valid && q_empty && (drop_q == '0);
  assign byp_take     = byp_avail && bus.id_ready && !bus.redirect_valid;
  assign bus.id_valid = !bus.redirect_valid && (!q_empty || byp_avail);
  assign bus.id_inst  = !q_empty ? q_head.inst : (byp_avail ? bus.imem_rsp_data : '0);
  assign bus.id_pc    = !q_empty ? q_head.pc   : (byp_avail ? pcq_head : '0);
`else
  assign byp_take     = 1'b0;
  assign bus.id_valid = !q_empty;
  assign bus.id_inst  = q_head.inst;
  assign bus.id_pc    = q_head.pc;
`endif

  // Stale responses (drop_q != 0) and anything arriving with a redirect never enter the queue.
  assign push    = bus.imem_rsp_valid && !bus.redirect_valid && (drop_q == '0) && !byp_take;
  assign pop     = !q_empty && bus.id_ready && !bus.redirect_valid;
  assign q_wdata = '{pc: pcq_head, inst: bus.imem_rsp_data};

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.redirect_valid),
    .push_i  (push),
    .wdata_i (q_wdata),
    .pop_i   (pop),
    .rdata_o (q_head),
    .count_o (q_count)
  );

  // Request PCs survive a redirect: stale responses still need their entry popped.
  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (1'b0),
    .push_i  (req_hs),
    .wdata_i (pc_q),
    .pop_i   (bus.imem_rsp_valid),
    .rdata_o (pcq_head),
    .count_o (pcq_count)
  );

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + CW'(req_hs) - CW'(bus.imem_rsp_valid);
    drop_d = drop_q;
    if (bus.redirect_valid) begin
      pc_d   = align_word(bus.redirect_pc);
      drop_d = out_d;
    end else begin
      if (req_hs) pc_d = pc_q + 32'd4;
      if (bus.imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      run_q  <= 1'b1;
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> (pcq_count != '0));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Scoreboard bench for inst_fetch_buffer: in-order memory model with programmable latency,
// expected fetch addresses and decode entries queued by directed stimulus, checked by monitors.
module tb_inst_fetch_buffer;
  import inst_fetch_buffer_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
`ifdef FETCH_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_buffer_if bus ();

  inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  logic [31:0] exp_addr[$];
  pend_t       pend[$];
  int n_vec = 0, n_err = 0;
  int cyc = 0, lat = 1, hs_total = 0, hs_limit = 0;
  int first_hs = -1, first_valid = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout, required completion", name);
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    exp_q.push_back(e);
  endtask

  // Memory: records handshakes at negedge, returns words in order lat cycles later.
  initial begin
    pend_t p;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        hs_total++;
        if (first_hs < 0) first_hs = cyc;
        if (exp_addr.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL req_addr: got unexpected request %08h, required none", bus.imem_req_addr);
        end else begin
          chk("req_addr", bus.imem_req_addr, exp_addr.pop_front());
        end
        p.addr = bus.imem_req_addr;
        p.due  = cyc + lat;
        pend.push_back(p);
      end
      @(posedge clk);
      #1;
      bus.imem_req_ready = (hs_total < hs_limit);
      bus.imem_rsp_valid = 1'b0;
      if (rst_n && pend.size() != 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hC0DE_0000 | {16'h0000, p.addr[15:0]};
        $display("mem rsp    addr=%08h data=%08h cyc=%0d", p.addr, bus.imem_rsp_data, cyc);
      end
    end
  end

  // Decode-side monitor: every consumed instruction must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.id_valid && first_valid < 0) first_valid = cyc;
      if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
        $display("id consume pc=%08h inst=%08h cyc=%0d", bus.id_pc, bus.id_inst, cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL id_entry: got pc %08h inst %08h, required none", bus.id_pc, bus.id_inst);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", bus.id_pc, e.pc);
          chk("id_inst", bus.id_inst, e.inst);
        end
      end
    end
  end

  task automatic drain(input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(posedge clk);
      done = (exp_q.size() == 0 && exp_addr.size() == 0 && pend.size() == 0);
    end
    if (!done) fail("drain");
    #1;
  endtask

  task automatic wait_hs(input int target, input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(posedge clk);
      done = (hs_total >= target);
    end
    if (!done) fail("wait_hs");
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    chk({tag, "_req_addr"},  bus.imem_req_addr, RST_PC);
    chk({tag, "_id_valid"},  32'(bus.id_valid), 32'd0);
    chk({tag, "_id_inst"},   bus.id_inst, 32'd0);
    chk({tag, "_id_pc"},     bus.id_pc, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");

    // Sequential fetch with PC wrap, latency 1, decode always ready
    @(posedge clk); #1;
    lat = 1;
    bus.id_ready = 1'b1;
    exp_addr.push_back(32'hFFFF_FFF8);
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0000_0000);
    expect_entry(32'hFFFF_FFF8, 32'hC0DE_FFF8);
    expect_entry(32'hFFFF_FFFC, 32'hC0DE_FFFC);
    expect_entry(32'h0000_0000, 32'hC0DE_0000);
    hs_limit = 3;
    rst_n = 1'b1;
    drain(100);
    chk("first_latency", 32'(first_valid - first_hs), 32'(EXP_LAT));

    // Decode stalled: credit limit caps at DEPTH, one pop frees one request
    bus.id_ready = 1'b0;
    base = hs_total;
    exp_addr.push_back(32'h0000_0004);
    exp_addr.push_back(32'h0000_0008);
    exp_addr.push_back(32'h0000_000C);
    exp_addr.push_back(32'h0000_0010);
    expect_entry(32'h0000_0004, 32'hC0DE_0004);
    expect_entry(32'h0000_0008, 32'hC0DE_0008);
    expect_entry(32'h0000_000C, 32'hC0DE_000C);
    expect_entry(32'h0000_0010, 32'hC0DE_0010);
    expect_entry(32'h0000_0014, 32'hC0DE_0014);
    hs_limit = hs_total + 10;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("fill_hs_count", 32'(hs_total - base), 32'd4);
    chk("fill_req_valid", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk); #1;
    bus.id_ready = 1'b1;
    exp_addr.push_back(32'h0000_0014);
    @(posedge clk); #1;
    bus.id_ready = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("refill_hs_count", 32'(hs_total - base), 32'd5);
    chk("refill_req_valid", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk); #1;
    hs_limit = hs_total;
    bus.id_ready = 1'b1;
    drain(100);

    // Redirect with three requests in flight at latency 3
    lat = 3;
    base = hs_total;
    exp_addr.push_back(32'h0000_0018);
    exp_addr.push_back(32'h0000_001C);
    exp_addr.push_back(32'h0000_0020);
    hs_limit = hs_total + 3;
    wait_hs(base + 3, 50);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    exp_addr.push_back(32'h0000_0100);
    exp_addr.push_back(32'h0000_0104);
    expect_entry(32'h0000_0100, 32'hC0DE_0100);
    expect_entry(32'h0000_0104, 32'hC0DE_0104);
    hs_limit = hs_total + 2;
    @(negedge clk);
    chk("redir1_req_valid", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir1_id_valid", 32'(bus.id_valid), 32'd0);
    chk("redir1_req_addr", bus.imem_req_addr, 32'h0000_0100);
    drain(100);

    // Redirect coinciding with a response and a decode pop; target low bits ignored
    lat = 1;
    bus.id_ready = 1'b0;
    base = hs_total;
    exp_addr.push_back(32'h0000_0108);
    exp_addr.push_back(32'h0000_010C);
    hs_limit = hs_total + 2;
    wait_hs(base + 2, 50);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0203;
    bus.id_ready       = 1'b1;
    exp_addr.push_back(32'h0000_0200);
    expect_entry(32'h0000_0200, 32'hC0DE_0200);
    hs_limit = hs_total + 1;
    @(negedge clk);
    chk("redir2_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("redir2_rsp_present", 32'(bus.imem_rsp_valid), 32'd1);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir2_id_valid", 32'(bus.id_valid), 32'd0);
    chk("redir2_req_addr", bus.imem_req_addr, 32'h0000_0200);
    drain(100);

    // Reset while responses are in flight
    lat = 2;
    bus.id_ready = 1'b0;
    base = hs_total;
    exp_addr.push_back(32'h0000_0204);
    exp_addr.push_back(32'h0000_0208);
    hs_limit = hs_total + 2;
    wait_hs(base + 2, 50);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst2");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.id_ready = 1'b1;
    exp_addr.push_back(RST_PC);
    expect_entry(32'hFFFF_FFF8, 32'hC0DE_FFF8);
    hs_limit = hs_total + 1;
    drain(100);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
